// File: rtl/rasterizer_pkg.sv
// Shared definitions for the 8x8 rasterizer display path: grid geometry,
// pixel-index field widths and the frame capture state encoding.
package rasterizer_pkg;

  localparam int GRID      = 8;
  localparam int PIX_COUNT = GRID * GRID;
  localparam int ROW_W     = 3;
  localparam int COL_W     = 3;
  localparam int IDX_W     = ROW_W + COL_W;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_CAPT = 1'b1
  } cap_state_e;

  function automatic logic [GRID-1:0] row_onehot(input logic [ROW_W-1:0] row);
    return GRID'(1) << row;
  endfunction

endpackage

// File: rtl/frame_capture.sv
// Captures the serial 64-pixel stream into a shadow buffer and flags a
// complete frame as pending until the display side commits it.
module frame_capture
  import rasterizer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start_i,
  input  logic                 pixel_i,
  input  logic                 commit_i,
  output logic [PIX_COUNT-1:0] shadow_o,
  output logic                 pending_o,
  output logic                 capturing_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_COUNT - 1);

  cap_state_e           state_q, state_d;
  logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
  logic [PIX_COUNT-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= C_IDLE;
      cap_idx_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_idx_q <= cap_idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  // A completing capture sets pending after the commit check, so a frame that
  // finishes in the commit cycle waits for the next scan-frame boundary.
  always_comb begin
    state_d   = state_q;
    cap_idx_d = cap_idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit_i) pending_d = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (frame_start_i) begin
          state_d   = C_CAPT;
          cap_idx_d = '0;
          pending_d = 1'b0;
        end
      end
      C_CAPT: begin
        if (frame_start_i) begin
          cap_idx_d = '0;
          pending_d = 1'b0;
        end else begin
          shadow_d[cap_idx_q] = pixel_i;
          cap_idx_d           = cap_idx_q + 1'b1;
          if (cap_idx_q == LAST_IDX) begin
            pending_d = 1'b1;
            state_d   = C_IDLE;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  assign shadow_o    = shadow_q;
  assign pending_o   = pending_q;
  assign capturing_o = (state_q == C_CAPT);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed 8x8 LED matrix driver: free-running row/dwell scan with
// per-row blanking and tear-free frame commit at the scan-frame boundary.
module matrix_scan_driver
  import rasterizer_pkg::*;
#(
  parameter int DWELL = 64,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [3:0] pixel_data,
  output logic [7:0] row_en,
  output logic [7:0] col_data,
  output logic       frame_ready,
  output logic       capturing
);

  localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0]   BLANK_C    = DW'(BLANK);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(GRID - 1);

  logic [ROW_W-1:0]     row_q, row_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [PIX_COUNT-1:0] display_q, display_d;
  logic [GRID-1:0]      row_en_q, row_en_d;
  logic [GRID-1:0]      col_data_q, col_data_d;
  logic                 frame_ready_q, frame_ready_d;

  logic [PIX_COUNT-1:0] shadow;
  logic                 pending;
  logic                 commit;
  logic                 pixel_unused;

  assign pixel_unused = ^pixel_data[3:1];

  frame_capture u_capture (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .pixel_i       (pixel_data[0]),
    .commit_i      (commit),
    .shadow_o      (shadow),
    .pending_o     (pending),
    .capturing_o   (capturing)
  );

  assign commit = pending && (row_q == ROW_LAST) && (dwell_q == DWELL_LAST);

  // Outputs are computed from next-state counters so the registered row
  // drive lines up with the scan position it belongs to.
  always_comb begin
    row_d   = row_q;
    dwell_d = dwell_q + 1'b1;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      row_d   = row_q + 1'b1;
    end
    display_d     = commit ? shadow : display_q;
    row_en_d      = (dwell_d >= BLANK_C) ? row_onehot(row_d) : '0;
    col_data_d    = display_d[{row_d, 3'b000} +: GRID];
    frame_ready_d = commit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q         <= '0;
      dwell_q       <= '0;
      display_q     <= '0;
      row_en_q      <= '0;
      col_data_q    <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      display_q     <= display_d;
      row_en_q      <= row_en_d;
      col_data_q    <= col_data_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign row_en      = row_en_q;
  assign col_data    = col_data_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with DWELL=16, BLANK=2; scan position
// is modelled by a cycle counter that restarts with reset.
module tb_matrix_scan_driver;

  localparam int DWELL    = 16;
  localparam int BLANK    = 2;
  localparam int FRAMECYC = 8 * DWELL;

  localparam logic [63:0] IMG_PIX19   = 64'h0000_0000_0008_0000;
  localparam logic [63:0] IMG_CHECKER = 64'hAA55_AA55_AA55_AA55;
  localparam logic [63:0] IMG_STRIPE  = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] IMG_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IMG_ZERO    = 64'h0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] pixel_data = 4'h0;
  logic [7:0] row_en;
  logic [7:0] col_data;
  logic       frame_ready;
  logic       capturing;

  int total = 0;
  int bad = 0;
  int tbCyc = 0;
  int frCount = 0;
  int frCycle = -1;
  int oneHotViol = 0;

  matrix_scan_driver #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pixel_data  (pixel_data),
    .row_en      (row_en),
    .col_data    (col_data),
    .frame_ready (frame_ready),
    .capturing   (capturing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) tbCyc <= 0;
    else        tbCyc <= tbCyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (frame_ready === 1'b1) begin
      frCount = frCount + 1;
      frCycle = tbCyc;
    end
    if ($countones(row_en) > 1) oneHotViol = oneHotViol + 1;
  end

  function automatic logic [7:0] expEn(input int cyc);
    int d = cyc % DWELL;
    int r = (cyc / DWELL) % 8;
    return (d >= BLANK) ? 8'(1 << r) : 8'h00;
  endfunction

  function automatic logic [7:0] expCol(input logic [63:0] img, input int cyc);
    int r = (cyc / DWELL) % 8;
    return img[r*8 +: 8];
  endfunction

  task automatic drive_frame(input logic [63:0] img);
    frame_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      frame_start = 1'b0;
      pixel_data  = {3'($urandom_range(0, 7)), img[k]};
      @(negedge clk);
    end
    pixel_data = 4'h0;
  endtask

  task automatic wait_ready(input int f0, input int limit);
    int guard = 0;
    while (frCount == f0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    frame_start = 1'b0;
    pixel_data = 4'h0;
    repeat (3) @(negedge clk);
    total++; if (row_en !== 8'h00) begin bad++; $display("[TB] FAIL reset_row_en got=%h exp=%h", row_en, 8'h00); end
    total++; if (col_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_col_data got=%h exp=%h", col_data, 8'h00); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_ready got=%b exp=0", frame_ready); end
    total++; if (capturing !== 1'b0) begin bad++; $display("[TB] FAIL reset_capturing got=%b exp=0", capturing); end
    rst_n = 1'b1;
    for (int i = 0; i < DWELL; i++) begin
      total++; if (row_en !== expEn(tbCyc)) begin bad++; $display("[TB] FAIL reset_first_row cyc=%0d got=%h exp=%h", tbCyc, row_en, expEn(tbCyc)); end
      total++; if (col_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_first_col cyc=%0d got=%h exp=%h", tbCyc, col_data, 8'h00); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_pixel;
    int f0 = frCount;
    total++; if (capturing !== 1'b0) begin bad++; $display("[TB] FAIL single_cap_before got=%b exp=0", capturing); end
    frame_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || k == 63) begin
        total++; if (capturing !== 1'b1) begin bad++; $display("[TB] FAIL single_cap_during k=%0d got=%b exp=1", k, capturing); end
      end
      frame_start = 1'b0;
      pixel_data  = {3'($urandom_range(0, 7)), IMG_PIX19[k]};
      @(negedge clk);
    end
    pixel_data = 4'h0;
    total++; if (capturing !== 1'b0) begin bad++; $display("[TB] FAIL single_cap_after got=%b exp=0", capturing); end
    wait_ready(f0, 2 * FRAMECYC + 10);
    total++; if (frCount !== f0 + 1) begin bad++; $display("[TB] FAIL single_ready_count got=%0d exp=%0d", frCount, f0 + 1); end
    total++; if (frCycle % FRAMECYC != 0) begin bad++; $display("[TB] FAIL single_ready_phase got=%0d exp=0", frCycle % FRAMECYC); end
    for (int i = 0; i < FRAMECYC; i++) begin
      total++; if (row_en !== expEn(tbCyc)) begin bad++; $display("[TB] FAIL single_row_en cyc=%0d got=%h exp=%h", tbCyc, row_en, expEn(tbCyc)); end
      total++; if (col_data !== expCol(IMG_PIX19, tbCyc)) begin bad++; $display("[TB] FAIL single_col cyc=%0d got=%h exp=%h", tbCyc, col_data, expCol(IMG_PIX19, tbCyc)); end
      @(negedge clk);
    end
    total++; if (frCount !== f0 + 1) begin bad++; $display("[TB] FAIL single_ready_once got=%0d exp=%0d", frCount, f0 + 1); end
  endtask

  task automatic test_restart;
    int f0 = frCount;
    frame_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      frame_start = 1'b0;
      pixel_data  = 4'h1;
      @(negedge clk);
    end
    drive_frame(IMG_CHECKER);
    wait_ready(f0, 2 * FRAMECYC + 10);
    total++; if (frCount !== f0 + 1) begin bad++; $display("[TB] FAIL restart_ready_count got=%0d exp=%0d", frCount, f0 + 1); end
    for (int i = 0; i < FRAMECYC; i++) begin
      total++; if (col_data !== expCol(IMG_CHECKER, tbCyc)) begin bad++; $display("[TB] FAIL restart_col cyc=%0d got=%h exp=%h", tbCyc, col_data, expCol(IMG_CHECKER, tbCyc)); end
      @(negedge clk);
    end
    total++; if (frCount !== f0 + 1) begin bad++; $display("[TB] FAIL restart_ready_once got=%0d exp=%0d", frCount, f0 + 1); end
  endtask

  task automatic test_tear_free;
    int f0;
    int guard = 0;
    while ((tbCyc % FRAMECYC) != FRAMECYC - 66 && guard < 2 * FRAMECYC) begin
      @(negedge clk);
      guard++;
    end
    total++; if ((tbCyc % FRAMECYC) != FRAMECYC - 66) begin bad++; $display("[TB] FAIL tear_align got=%0d exp=%0d", tbCyc % FRAMECYC, FRAMECYC - 66); end
    f0 = frCount;
    fork
      begin
        drive_frame(IMG_STRIPE);
        drive_frame(IMG_ONES);
      end
      begin
        for (int i = 0; i < 66; i++) begin
          total++; if (col_data !== expCol(IMG_CHECKER, tbCyc)) begin bad++; $display("[TB] FAIL tear_old_col cyc=%0d got=%h exp=%h", tbCyc, col_data, expCol(IMG_CHECKER, tbCyc)); end
          @(negedge clk);
        end
        total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL tear_ready_first got=%b exp=1", frame_ready); end
        for (int i = 0; i < FRAMECYC; i++) begin
          total++; if (col_data !== expCol(IMG_STRIPE, tbCyc)) begin bad++; $display("[TB] FAIL tear_mid_col cyc=%0d got=%h exp=%h", tbCyc, col_data, expCol(IMG_STRIPE, tbCyc)); end
          @(negedge clk);
        end
        total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL tear_ready_second got=%b exp=1", frame_ready); end
        for (int i = 0; i < FRAMECYC; i++) begin
          total++; if (col_data !== expCol(IMG_ONES, tbCyc)) begin bad++; $display("[TB] FAIL tear_new_col cyc=%0d got=%h exp=%h", tbCyc, col_data, expCol(IMG_ONES, tbCyc)); end
          @(negedge clk);
        end
      end
    join
    total++; if (frCount !== f0 + 2) begin bad++; $display("[TB] FAIL tear_ready_count got=%0d exp=%0d", frCount, f0 + 2); end
  endtask

  task automatic test_reset_mid_capture;
    int f0 = frCount;
    frame_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      frame_start = 1'b0;
      pixel_data  = 4'h1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pixel_data = 4'h0;
    total++; if (capturing !== 1'b0) begin bad++; $display("[TB] FAIL midrst_capturing got=%b exp=0", capturing); end
    for (int i = 0; i < 2 * FRAMECYC; i++) begin
      total++; if (row_en !== expEn(tbCyc)) begin bad++; $display("[TB] FAIL midrst_row_en cyc=%0d got=%h exp=%h", tbCyc, row_en, expEn(tbCyc)); end
      total++; if (col_data !== expCol(IMG_ZERO, tbCyc)) begin bad++; $display("[TB] FAIL midrst_col cyc=%0d got=%h exp=%h", tbCyc, col_data, 8'h00); end
      @(negedge clk);
    end
    total++; if (frCount !== f0) begin bad++; $display("[TB] FAIL midrst_ready_count got=%0d exp=%0d", frCount, f0); end
  endtask

  task automatic test_blanking;
    int guard = 0;
    while ((tbCyc % DWELL) != 0 && guard < 2 * DWELL) begin
      @(negedge clk);
      guard++;
    end
    for (int r = 0; r < 8; r++) begin
      int blankCnt = 0;
      int onCnt = 0;
      logic [7:0] expRow;
      expRow = 8'(1 << ((tbCyc / DWELL) % 8));
      for (int d = 0; d < DWELL; d++) begin
        if (d < BLANK && row_en === 8'h00) blankCnt++;
        if (d >= BLANK && row_en === expRow) onCnt++;
        @(negedge clk);
      end
      total++; if (blankCnt != BLANK) begin bad++; $display("[TB] FAIL blank_cycles row=%0d got=%0d exp=%0d", r, blankCnt, BLANK); end
      total++; if (onCnt != DWELL - BLANK) begin bad++; $display("[TB] FAIL drive_cycles row=%0d got=%0d exp=%0d", r, onCnt, DWELL - BLANK); end
    end
    total++; if (oneHotViol != 0) begin bad++; $display("[TB] FAIL onehot_violations got=%0d exp=0", oneHotViol); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_restart();
    test_tear_free();
    test_reset_mid_capture();
    test_blanking();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
